dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 135 +++++++++++++
 tb/tb_dm_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Data-memory port arbiter: CPU MEM stage has priority, the external port is forced a
// grant after STARVE_LIMIT lost cycles. Optional statistics counters under DM_ARB_STATS_EN.
module dm_arbiter #(
    parameter int AW           = 7,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_din,
    input  logic [DW-1:0] dm_dout
`ifdef DM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_stall,
    output logic [15:0]   stat_ext
`endif
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]    wait_q;
    logic [3:0]    wait_d;
    logic          rvalid_q;
    logic          rvalid_d;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;
    logic          force_s;
    logic          ext_own_s;
    logic          we_s;

    // Port ownership and memory-side steering; ext cannot own the port while in reset.
    always_comb begin
        force_s   = (wait_q == LIMIT);
        ext_own_s = rstn & ext_req & (~cpu_req | force_s);
        if (ext_own_s) begin
            dm_addr = ext_addr;
            dm_din  = ext_wdata;
            we_s    = ext_we;
        end else begin
            dm_addr = cpu_addr;
            dm_din  = cpu_wdata;
            we_s    = cpu_req & cpu_we;
        end
        dm_we      = rstn & we_s;
        ext_gnt    = ext_own_s;
        cpu_stall  = ext_own_s & cpu_req;
        cpu_rdata  = dm_dout;
        ext_rvalid = rvalid_q;
        ext_rdata  = rdata_q;
    end

    // Next-state for the starvation counter and the ext read-return register.
    always_comb begin
        wait_d   = wait_q;
        rvalid_d = ext_own_s & ~ext_we;
        rdata_d  = rdata_q;
        if (ext_own_s || !ext_req) begin
            wait_d = 4'd0;
        end else if (wait_q < LIMIT) begin
            wait_d = wait_q + 4'd1;
        end else begin
            wait_d = wait_q;
        end
        if (rvalid_d) begin
            rdata_d = dm_dout;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers; an asynchronous reset also cancels a pending read return.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_q   <= 4'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wait_q   <= wait_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef DM_ARB_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;
    logic [15:0] ext_cnt_q;
    logic [15:0] ext_cnt_d;

    // Saturating event counters for stalled CPU cycles and ext grants.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        ext_cnt_d   = ext_cnt_q;
        if (cpu_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (ext_own_s && (ext_cnt_q != 16'hFFFF)) begin
            ext_cnt_d = ext_cnt_q + 16'd1;
        end else begin
            ext_cnt_d = ext_cnt_q;
        end
        stat_stall = stall_cnt_q;
        stat_ext   = ext_cnt_q;
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= 16'd0;
            ext_cnt_q   <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            ext_cnt_q   <= ext_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios followed by random traffic,
// each cycle compared against a cycle-level behavioural model with a shadow memory.
module tb_dm_arbiter;
    localparam int AW  = 7;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cpu_req, cpu_we, ext_req, ext_we;
    logic [AW-1:0] cpu_addr, ext_addr;
    logic [DW-1:0] cpu_wdata, ext_wdata;
    logic [DW-1:0] cpu_rdata, ext_rdata, dm_din, dm_dout;
    logic          cpu_stall, ext_gnt, ext_rvalid, dm_we;
    logic [AW-1:0] dm_addr;
`ifdef DM_ARB_STATS_EN
    logic [15:0]   stat_stall, stat_ext;
`endif

    logic [DW-1:0] mem     [0:127] = '{default: 32'h0};
    logic [DW-1:0] ref_mem [0:127] = '{default: 32'h0};

    int            checks = 0;
    int            errors = 0;
    int            m_wait;
    logic          m_rv;
    logic [DW-1:0] m_rdata;
    int            m_sstall, m_sext;
    logic          o_gnt, o_stall, o_rv;
    logic [DW-1:0] o_rdata, o_erdata;
    logic          gnt_seq [0:5];
    logic          stall_seq [0:5];

    always #5 clk = ~clk;

    assign dm_dout = mem[dm_addr];
    always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_din;

    dm_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rstn(rstn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout)
`ifdef DM_ARB_STATS_EN
        , .stat_stall(stat_stall), .stat_ext(stat_ext)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, advance the model.
    task automatic cyc(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                       input logic [DW-1:0] cwd, input logic ereq, input logic ewe,
                       input logic [AW-1:0] eaddr, input logic [DW-1:0] ewd);
        logic          e_g, x_we;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_din;
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        ext_req = ereq; ext_we = ewe; ext_addr = eaddr; ext_wdata = ewd;
        if (!rstn) begin
            m_wait = 0; m_rv = 1'b0; m_rdata = '0; m_sstall = 0; m_sext = 0;
        end
        e_g    = rstn && ereq && (!creq || (m_wait == LIM));
        x_addr = e_g ? eaddr : caddr;
        x_din  = e_g ? ewd : cwd;
        x_we   = rstn && (e_g ? ewe : (creq && cwe));
        #4;
        o_gnt = ext_gnt; o_stall = cpu_stall; o_rv = ext_rvalid;
        o_rdata = cpu_rdata; o_erdata = ext_rdata;
        chk("ext_gnt", {31'd0, ext_gnt}, {31'd0, e_g});
        chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, e_g && creq});
        chk("dm_we", {31'd0, dm_we}, {31'd0, x_we});
        chk("dm_addr", {25'd0, dm_addr}, {25'd0, x_addr});
        if (x_we) chk("dm_din", dm_din, x_din);
        chk("cpu_rdata", cpu_rdata, ref_mem[x_addr]);
        chk("ext_rvalid", {31'd0, ext_rvalid}, {31'd0, m_rv});
        chk("ext_rdata", ext_rdata, m_rdata);
`ifdef DM_ARB_STATS_EN
        chk("stat_stall", {16'd0, stat_stall}, m_sstall);
        chk("stat_ext", {16'd0, stat_ext}, m_sext);
`endif
        if (rstn) begin
            m_rv = e_g && !ewe;
            if (m_rv) m_rdata = ref_mem[eaddr];
            if (x_we) ref_mem[x_addr] = x_din;
            if (e_g || !ereq) m_wait = 0;
            else if (m_wait < LIM) m_wait = m_wait + 1;
            if (e_g && creq && (m_sstall < 65535)) m_sstall++;
            if (e_g && (m_sext < 65535)) m_sext++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
        @(posedge clk);
        #1;
        // Reset: a CPU store must not reach the memory.
        cyc(1'b1, 1'b1, 7'd5, 32'h11111111, 1'b1, 1'b0, 7'd1, 32'h0);
        chk("rst_mem5", mem[5], 32'h0);
        rstn = 1'b1;
        cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);

        // CPU only store/load.
        cyc(1'b1, 1'b1, 7'd5, 32'hDEADBEEF, 1'b0, 1'b0, 7'd0, 32'h0);
        chk("cpu_st_stall", {31'd0, o_stall}, 32'd0);
        cyc(1'b1, 1'b0, 7'd5, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);
        chk("cpu_ld_data", o_rdata, 32'hDEADBEEF);
        chk("cpu_ld_stall", {31'd0, o_stall}, 32'd0);

        // Ext only write/read.
        cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b1, 1'b1, 7'd9, 32'h12345678);
        chk("ext_wr_gnt", {31'd0, o_gnt}, 32'd1);
        cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b1, 1'b0, 7'd9, 32'h0);
        chk("ext_rd_gnt", {31'd0, o_gnt}, 32'd1);
        chk("ext_rd_norv", {31'd0, o_rv}, 32'd0);
        cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);
        chk("ext_rv", {31'd0, o_rv}, 32'd1);
        chk("ext_rdata9", o_erdata, 32'h12345678);
        cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);
        chk("ext_rv_once", {31'd0, o_rv}, 32'd0);

        // Starvation: ext forced through in cycle 4 only.
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b0, 7'd0, 32'h0, 1'b1, 1'b0, 7'd1, 32'h0);
            gnt_seq[i] = o_gnt;
            stall_seq[i] = o_stall;
            if (i == 4) chk("starve_wait0", {28'd0, dut.wait_q}, 32'd0);
        end
        for (int i = 0; i < 6; i++) begin
            chk("starve_gnt", {31'd0, gnt_seq[i]}, (i == 4) ? 32'd1 : 32'd0);
            chk("starve_stall", {31'd0, stall_seq[i]}, (i == 4) ? 32'd1 : 32'd0);
        end

        // Stalled store in the forced cycle, then CPU retry.
        cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b0, 7'd0, 32'h0, 1'b1, 1'b1, 7'd3, 32'hAAAA0000);
        cyc(1'b1, 1'b1, 7'd3, 32'h55555555, 1'b1, 1'b1, 7'd3, 32'hAAAA0000);
        chk("fst_gnt", {31'd0, o_gnt}, 32'd1);
        chk("fst_mem_ext", mem[3], 32'hAAAA0000);
        cyc(1'b1, 1'b1, 7'd3, 32'h55555555, 1'b0, 1'b0, 7'd0, 32'h0);
        chk("fst_mem_cpu", mem[3], 32'h55555555);

        // Reset between ext read grant and its rvalid cycle.
        cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b1, 1'b0, 7'd9, 32'h0);
        chk("rstrd_gnt", {31'd0, o_gnt}, 32'd1);
        rstn = 1'b0;
        cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);
        chk("rstrd_rv0", {31'd0, o_rv}, 32'd0);
        rstn = 1'b1;
        cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);
        chk("rstrd_rv1", {31'd0, o_rv}, 32'd0);
        chk("rstrd_rdata", o_erdata, 32'h0);
        chk("rstrd_wait", {28'd0, dut.wait_q}, 32'd0);

        // Random traffic over a small address window to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)),
                $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                7'($urandom_range(0, 7)), $urandom);
        end

`ifdef DM_ARB_STATS_EN
        rstn = 1'b0;
        cyc(1'b0, 1'b0, 7'd0, 32'h0, 1'b0, 1'b0, 7'd0, 32'h0);
        rstn = 1'b1;
        for (int i = 0; i < 15; i++)
            cyc(1'b1, 1'b0, 7'd0, 32'h0, 1'b1, 1'b0, 7'd1, 32'h0);
        chk("stat_ext3", {16'd0, stat_ext}, 32'd3);
        chk("stat_stall3", {16'd0, stat_stall}, 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
